// File: rtl/buffer_arbiter.sv
// Four-way round-robin arbiter feeding a one-entry registered output stage.
// Define ARBITER_LOCK_EN to build burst locking (OPEN/LOCKED FSM with owner).
module buffer_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4*WIDTH-1:0] data_in,
    input  logic [3:0]         write_in,
    input  logic [3:0]         lock_in,
    output logic [3:0]         write_ready,
    input  logic               next_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               write_out,
    output logic [1:0]         grant_id
);

    logic [1:0] last_grant;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       stage_ready;
    logic       transfer;
    logic [3:0] eligible;
    logic [3:0] request;

`ifdef ARBITER_LOCK_EN
    typedef enum logic {
        OPEN,
        LOCKED
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] owner;
    logic [1:0] next_owner;

    // While locked only the owner may win, even if it is currently idle.
    assign eligible = (state == LOCKED) ? (4'b0001 << owner) : 4'b1111;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= OPEN;
            owner <= 2'd0;
        end else begin
            state <= next_state;
            owner <= next_owner;
        end
    end

    always_comb begin
        next_state = state;
        next_owner = owner;
        unique case (state)
            OPEN: begin
                if (transfer && lock_in[winner]) begin
                    next_state = LOCKED;
                    next_owner = winner;
                end
            end
            LOCKED: begin
                if (transfer && !lock_in[owner]) begin
                    next_state = OPEN;
                end
            end
            default: next_state = OPEN;
        endcase
    end
`else
    logic unused_lock;

    assign unused_lock = ^lock_in;
    assign eligible    = 4'b1111;
`endif

    assign request     = write_in & eligible;
    assign stage_ready = ~write_out | next_ready;

    // Search starts one past the last grant and wraps modulo 4.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && request[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign transfer    = stage_ready & found;
    assign write_ready = transfer ? (4'b0001 << winner) : 4'b0000;

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out   <= '0;
            write_out  <= 1'b0;
            grant_id   <= 2'd0;
            last_grant <= 2'd3;
        end else if (transfer) begin
            data_out   <= data_in[winner*WIDTH +: WIDTH];
            write_out  <= 1'b1;
            grant_id   <= winner;
            last_grant <= winner;
        end else if (write_out && next_ready) begin
            data_out  <= '0;
            write_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed bench for buffer_arbiter with a cycle-level reference model.
// Builds with or without ARBITER_LOCK_EN.
module tb_buffer_arbiter;

    localparam int W = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [4*W-1:0] data_in = '0;
    logic [3:0]     write_in = '0;
    logic [3:0]     lock_in = '0;
    logic [3:0]     write_ready;
    logic           next_ready = 1'b0;
    logic [W-1:0]   data_out;
    logic           write_out;
    logic [1:0]     grant_id;

    int total = 0;
    int bad = 0;

    buffer_arbiter #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .write_in    (write_in),
        .lock_in     (lock_in),
        .write_ready (write_ready),
        .next_ready  (next_ready),
        .data_out    (data_out),
        .write_out   (write_out),
        .grant_id    (grant_id)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers, advanced once per cycle.
    bit     m_ok = 0;
    int     m_last;
    bit     m_locked;
    int     m_owner;
    int     m_data;
    bit     m_wo;
    int     m_gid;

    always @(negedge clock) begin
        int  win;
        int  cand;
        bit  sr;
        int  exp_wr;
        win = -1;
        for (int k = 1; k <= 4; k++) begin
            cand = (m_last + k) % 4;
            if (win < 0 && write_in[cand] && (!m_locked || cand == m_owner))
                win = cand;
        end
        sr = !m_wo || next_ready;
        exp_wr = (sr && win >= 0) ? (1 << win) : 0;
        if (m_ok) begin
            check("model write_ready", int'(write_ready), exp_wr);
            check("model write_out", int'(write_out), int'(m_wo));
            check("model data_out", int'(data_out), m_data);
            check("model grant_id", int'(grant_id), m_gid);
        end
        if (reset) begin
            m_ok = 1; m_last = 3; m_locked = 0; m_owner = 0;
            m_data = 0; m_wo = 0; m_gid = 0;
        end else if (m_ok) begin
            if (sr && win >= 0) begin
`ifdef ARBITER_LOCK_EN
                if (!m_locked && lock_in[win]) begin
                    m_locked = 1;
                    m_owner = win;
                end else if (m_locked && !lock_in[win]) begin
                    m_locked = 0;
                end
`endif
                m_data = int'(data_in[win*W +: W]);
                m_wo = 1; m_gid = win; m_last = win;
            end else if (m_wo && next_ready) begin
                m_data = 0; m_wo = 0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    int seq [$];
    int exp_seq [$];

    initial begin
        int beats;
        int exp031 [5];
        exp031 = '{1, 2, 4, 8, 1};
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        step(); step();
        check("reset write_out", int'(write_out), 0);
        check("reset data_out", int'(data_out), 0);
        check("reset grant_id", int'(grant_id), 0);

        // Full contention rotates 0,1,2,3,0.
        reset = 0; write_in = 4'b1111; next_ready = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr write_ready", int'(write_ready), exp031[i]);
            step();
            check("rr grant_id", int'(grant_id), i % 4);
            check("rr write_out", int'(write_out), 1);
            check("rr data_out", int'(data_out), 8'h11 * ((i % 4) + 1));
        end
        write_in = 0; step();
        check("drain write_out", int'(write_out), 0);

        // Stall with a held payload.
        data_in[2*W +: W] = 8'hA5; write_in = 4'b0100; next_ready = 0;
        #1;
        check("single write_ready", int'(write_ready), 4'b0100);
        step();
        write_in = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall write_ready", int'(write_ready), 0);
            check("stall data_out", int'(data_out), 8'hA5);
            check("stall grant_id", int'(grant_id), 2);
            step();
        end
        write_in = 0; next_ready = 1; step();
        check("release write_out", int'(write_out), 0);
        check("release data_out", int'(data_out), 0);

        // Drain and refill in the same cycle.
        write_in = 4'b0001; step();
        data_in[1*W +: W] = 8'h3C; write_in = 4'b0010; step();
        check("refill data_out", int'(data_out), 8'h3C);
        check("refill write_out", int'(write_out), 1);
        check("refill grant_id", int'(grant_id), 1);

        // Reset beats a pending transfer.
        write_in = 4'b0001; reset = 1; step();
        check("rst-prio write_out", int'(write_out), 0);
        check("rst-prio data_out", int'(data_out), 0);
        check("rst-prio grant_id", int'(grant_id), 0);
        reset = 0; write_in = 0; step();

        // Park last grant at requester 0, then run the burst pattern.
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        write_in = 4'b0001; step();
        beats = 0;
`ifdef ARBITER_LOCK_EN
        exp_seq = '{1, 1, 1, 1, 3};
`else
        exp_seq = '{1, 3, 0, 1};
`endif
        for (int c = 0; c < 40 && seq.size() < exp_seq.size(); c++) begin
            write_in = 4'b1001 | ((beats < 4) ? 4'b0010 : 4'b0000);
            lock_in = (beats < 3) ? 4'b0010 : 4'b0000;
            data_in[1*W +: W] = 8'(8'hB0 + beats);
            #1;
            if (write_ready != 0) seq.push_back(onehot_idx(write_ready));
            if (write_ready[1]) beats++;
            step();
        end
        write_in = 0; lock_in = 0;
        check("burst grant count", seq.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size(); i++)
            check("burst grant", (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
